// File: rtl/mul_port_arbiter_pkg.sv
// mdu_pkg: shared types and constants for the two-port multiplier arbiter.
package mdu_pkg;

  typedef enum logic [1:0] {
    MUL    = 2'b00,
    MULH   = 2'b01,
    MULHSU = 2'b10,
    MULHU  = 2'b11
  } mul_type_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } arb_state_e;

  localparam int NUM_MUL_PORTS = 2;

endpackage

// File: rtl/mul_port_arbiter_if.sv
// mul_port_arbiter_if: requester ports, response slots and the multiplier
// handshake. slave = arbiter side, master = requesters plus multiplier.
interface mul_port_arbiter_if import mdu_pkg::*; #(
  parameter int TAG_W = 5
);
  logic [NUM_MUL_PORTS-1:0]            req_valid;
  logic [NUM_MUL_PORTS-1:0]            req_ready;
  logic [NUM_MUL_PORTS-1:0][1:0]       req_type;
  logic [NUM_MUL_PORTS-1:0][31:0]      req_rs1;
  logic [NUM_MUL_PORTS-1:0][31:0]      req_rs2;
  logic [NUM_MUL_PORTS-1:0][TAG_W-1:0] req_tag;
  logic [NUM_MUL_PORTS-1:0]            rsp_valid;
  logic [NUM_MUL_PORTS-1:0]            rsp_ready;
  logic [NUM_MUL_PORTS-1:0][31:0]      rsp_data;
  logic [NUM_MUL_PORTS-1:0][TAG_W-1:0] rsp_tag;
  logic [NUM_MUL_PORTS-1:0]            flush;
  logic                                mul_in_valid;
  logic [1:0]                          mul_type;
  logic [31:0]                         mul_multiplicand;
  logic [31:0]                         mul_multiplier;
  logic                                cpu_busy;
  logic [31:0]                         mul_out;
  logic                                mul_out_valid;
  logic                                mul_busy;

  modport slave (
    input  req_valid, req_type, req_rs1, req_rs2, req_tag, rsp_ready, flush,
           mul_out, mul_out_valid, mul_busy,
    output req_ready, rsp_valid, rsp_data, rsp_tag,
           mul_in_valid, mul_type, mul_multiplicand, mul_multiplier, cpu_busy
  );

  modport master (
    output req_valid, req_type, req_rs1, req_rs2, req_tag, rsp_ready, flush,
           mul_out, mul_out_valid, mul_busy,
    input  req_ready, rsp_valid, rsp_data, rsp_tag,
           mul_in_valid, mul_type, mul_multiplicand, mul_multiplier, cpu_busy
  );

endinterface

// File: rtl/mul_rr_arbiter.sv
// mul_rr_arbiter: 2-way grant logic. Round-robin when MUL_ARB_RR_EN is
// defined, otherwise fixed priority with port 0 winning.
// rdy_o[i] never depends on req_i[i], only on availability and the other
// port's eligibility, so requesters may wait on ready before asserting valid.
module mul_rr_arbiter import mdu_pkg::*; (
`ifdef MUL_ARB_RR_EN
  input  logic                     clk,
  input  logic                     rst,
`endif
  input  logic [NUM_MUL_PORTS-1:0] avail_i,
  input  logic [NUM_MUL_PORTS-1:0] req_i,
  output logic [NUM_MUL_PORTS-1:0] rdy_o,
  output logic [NUM_MUL_PORTS-1:0] gnt_o
);
  logic [NUM_MUL_PORTS-1:0] elig;
  logic                     prio0;

  assign elig = avail_i & req_i;

`ifdef MUL_ARB_RR_EN
  // ptr_q holds the index of the last granted port; reset 1 so port 0 goes first.
  logic ptr_q, ptr_d;
  assign ptr_d = (|gnt_o) ? gnt_o[1] : ptr_q;
  assign prio0 = ptr_q;

  // last-grant pointer, moved on every accept
  always_ff @(posedge clk) begin
    if (rst) ptr_q <= 1'b1;
    else     ptr_q <= ptr_d;
  end
`else
  assign prio0 = 1'b1;
`endif

  assign rdy_o[0] = avail_i[0] & (prio0  | ~elig[1]);
  assign rdy_o[1] = avail_i[1] & (~prio0 | ~elig[0]);
  assign gnt_o    = rdy_o & req_i;

endmodule

// File: rtl/mul_port_arbiter.sv
// mul_port_arbiter: shares one radix-4 multiplier between two requester
// ports, with a one-entry response slot per port and per-port flush.
// Build option: MUL_ARB_RR_EN selects round-robin arbitration.
module mul_port_arbiter import mdu_pkg::*; #(
  parameter int TAG_W = 5
) (
  input logic               clk,
  input logic               rst,
  mul_port_arbiter_if.slave bus
);
  arb_state_e                          state_q, state_d;
  mul_type_e                           type_q;
  logic [31:0]                         rs1_q, rs2_q;
  logic [TAG_W-1:0]                    tag_q;
  logic                                owner_q;
  logic                                killed_q;
  logic [NUM_MUL_PORTS-1:0]            rsp_valid_q;
  logic [NUM_MUL_PORTS-1:0][31:0]      rsp_data_q;
  logic [NUM_MUL_PORTS-1:0][TAG_W-1:0] rsp_tag_q;

  logic                                can_grant, accept, gidx, capture, issue_pulse;
  logic [NUM_MUL_PORTS-1:0]            avail, rdy, gnt;

  // A port may be granted only when idle, the multiplier is free, its slot is
  // empty and it is not being flushed.
  assign can_grant = (state_q == IDLE) & ~bus.mul_busy & ~rst;
  assign avail     = {NUM_MUL_PORTS{can_grant}} & ~rsp_valid_q & ~bus.flush;
  assign accept    = |gnt;
  assign gidx      = gnt[1];

  mul_rr_arbiter u_arb (
`ifdef MUL_ARB_RR_EN
    .clk     (clk),
    .rst     (rst),
`endif
    .avail_i (avail),
    .req_i   (bus.req_valid),
    .rdy_o   (rdy),
    .gnt_o   (gnt)
  );

  // Result is dropped if the owner was flushed earlier or in the capture cycle.
  assign capture = (state_q == WAIT) & bus.mul_out_valid & ~killed_q & ~bus.flush[owner_q];

  // FSM next state and the one-cycle start pulse
  always_comb begin
    state_d     = state_q;
    issue_pulse = 1'b0;
    case (state_q)
      IDLE:    if (accept) state_d = ISSUE;
      ISSUE: begin
        issue_pulse = 1'b1;
        state_d     = WAIT;
      end
      WAIT:    if (bus.mul_out_valid) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Operand/tag/owner latch on accept; kill flag for flushed in-flight work
  always_ff @(posedge clk) begin
    if (rst) begin
      type_q   <= MUL;
      rs1_q    <= '0;
      rs2_q    <= '0;
      tag_q    <= '0;
      owner_q  <= 1'b0;
      killed_q <= 1'b0;
    end else if (accept) begin
      type_q   <= mul_type_e'(bus.req_type[gidx]);
      rs1_q    <= bus.req_rs1[gidx];
      rs2_q    <= bus.req_rs2[gidx];
      tag_q    <= bus.req_tag[gidx];
      owner_q  <= gidx;
      killed_q <= 1'b0;
    end else if ((state_q != IDLE) && bus.flush[owner_q]) begin
      killed_q <= 1'b1;
    end
  end

  // Response slots: drained by consumer or flush, filled on capture. The owner
  // slot is always empty at capture, so the fill never races a drain.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      rsp_tag_q   <= '0;
    end else begin
      for (int i = 0; i < NUM_MUL_PORTS; i++)
        if (bus.rsp_ready[i] || bus.flush[i]) rsp_valid_q[i] <= 1'b0;
      if (capture) begin
        rsp_valid_q[owner_q] <= 1'b1;
        rsp_data_q[owner_q]  <= bus.mul_out;
        rsp_tag_q[owner_q]   <= tag_q;
      end
    end
  end

  assign bus.req_ready        = rdy;
  assign bus.rsp_valid        = rsp_valid_q;
  assign bus.rsp_data         = rsp_data_q;
  assign bus.rsp_tag          = rsp_tag_q;
  assign bus.mul_in_valid     = issue_pulse;
  assign bus.mul_type         = type_q;
  assign bus.mul_multiplicand = rs1_q;
  assign bus.mul_multiplier   = rs2_q;
  // The result is always taken on the first DONE cycle, so never stall it.
  assign bus.cpu_busy         = 1'b0;

endmodule

// File: tb/tb_mul_port_arbiter.sv
// tb_mul_port_arbiter: directed bench with a cycle-timed multiplier model
// (start, PRE_COMPUTE, 17 COMPUTE cycles, DONE on the 19th cycle after start).
module tb_mul_port_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   nstart = 0;
  int   gq[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mul_port_arbiter_if #(.TAG_W(5)) bus ();

  mul_port_arbiter #(.TAG_W(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // multiplier model
  int          mcnt = 0;
  logic [1:0]  mt;
  logic [31:0] ma, mb;

  function automatic logic [31:0] mulres(input logic [1:0] t, input logic [31:0] a, input logic [31:0] b);
    logic signed [65:0] sa, sb, p;
    sa = (t == 2'b01 || t == 2'b10) ? {{34{a[31]}}, a} : {34'b0, a};
    sb = (t == 2'b01) ? {{34{b[31]}}, b} : {34'b0, b};
    p  = sa * sb;
    return (t == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  always @(posedge clk) begin
    if (rst) mcnt <= 0;
    else if (mcnt == 0) begin
      if (bus.mul_in_valid) begin
        mcnt <= 1;
        mt   <= bus.mul_type;
        ma   <= bus.mul_multiplicand;
        mb   <= bus.mul_multiplier;
      end
    end else if (mcnt == 19) mcnt <= 0;
    else mcnt <= mcnt + 1;
  end

  assign bus.mul_busy      = (mcnt != 0);
  assign bus.mul_out_valid = (mcnt == 19);
  assign bus.mul_out       = mulres(mt, ma, mb);

  // grant order and start-pulse monitors
  always @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 2; i++)
        if (bus.req_valid[i] && bus.req_ready[i]) gq.push_back(i);
      if (bus.mul_in_valid) nstart <= nstart + 1;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", nm, obs, exp);
    end
  endtask

  task automatic setreq(input int p, input logic [1:0] t, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] tg);
    bus.req_type[p] = t;
    bus.req_rs1[p]  = a;
    bus.req_rs2[p]  = b;
    bus.req_tag[p]  = tg;
  endtask

  // Raise valid now (at a negedge), wait for accept, return the accept cycle,
  // and drop valid at the following negedge.
  task automatic issue(input int p, input logic [1:0] t, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] tg, output int t0);
    bit ok = 0;
    setreq(p, t, a, b, tg);
    bus.req_valid[p] = 1'b1;
    for (int k = 0; k < 100; k++) begin
      #1;
      if (bus.req_ready[p]) begin ok = 1; break; end
      @(negedge clk);
    end
    chk("accept", {31'b0, ok}, 32'd1);
    t0 = cyc;
    @(negedge clk);
    bus.req_valid[p] = 1'b0;
  endtask

  task automatic expect_rsp(input int p, input int t0, input logic [1:0] t,
                            input logic [31:0] exp, input logic [4:0] tg);
    while (cyc < t0 + 20) @(negedge clk);
    chk("done_t20", {31'b0, bus.mul_out_valid}, 32'd1);
    chk("rsp_early", {31'b0, bus.rsp_valid[p]}, 32'd0);
    chk("type_held", {30'b0, bus.mul_type}, {30'b0, t});
    @(negedge clk);
    chk("rsp_valid", {31'b0, bus.rsp_valid[p]}, 32'd1);
    chk("rsp_data", bus.rsp_data[p], exp);
    chk("rsp_tag", {27'b0, bus.rsp_tag[p]}, {27'b0, tg});
  endtask

  initial begin
    int t0, t1, t2, n0;
    int g[4];
    bus.req_valid = '0;
    bus.rsp_ready = 2'b11;
    bus.flush     = '0;
    setreq(0, 2'b00, 0, 0, 0);
    setreq(1, 2'b00, 0, 0, 0);

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_req_ready", {30'b0, bus.req_ready}, 32'd0);
    chk("rst_rsp_valid", {30'b0, bus.rsp_valid}, 32'd0);
    chk("rst_rsp_data0", bus.rsp_data[0], 32'd0);
    chk("rst_in_valid", {31'b0, bus.mul_in_valid}, 32'd0);
    chk("rst_type", {30'b0, bus.mul_type}, 32'd0);
    chk("cpu_busy", {31'b0, bus.cpu_busy}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // single MUL: 7*6 = 42, start pulse only at T+1
    n0 = nstart;
    issue(0, 2'b00, 32'd7, 32'd6, 5'd3, t0);
    chk("start_t1", {31'b0, bus.mul_in_valid}, 32'd1);
    chk("opa", bus.mul_multiplicand, 32'd7);
    @(negedge clk);
    chk("start_t2", {31'b0, bus.mul_in_valid}, 32'd0);
    expect_rsp(0, t0, 2'b00, 32'd42, 5'd3);
    chk("one_start", nstart - n0, 32'd1);
    @(negedge clk);
    chk("slot_drained", {31'b0, bus.rsp_valid[0]}, 32'd0);

    // sign modes
    issue(0, 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, t0);
    expect_rsp(0, t0, 2'b11, 32'hFFFF_FFFE, 5'd4);
    @(negedge clk);
    issue(0, 2'b01, 32'hFFFF_FFFF, 32'd1, 5'd5, t0);
    expect_rsp(0, t0, 2'b01, 32'hFFFF_FFFF, 5'd5);
    @(negedge clk);
    issue(0, 2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6, t0);
    expect_rsp(0, t0, 2'b10, 32'hFFFF_FFFF, 5'd6);
    repeat (2) @(negedge clk);

    // contention: both ports request continuously; last grant was port 0
    gq.delete();
    setreq(0, 2'b00, 32'd2, 32'd3, 5'd10);
    setreq(1, 2'b00, 32'd4, 32'd5, 5'd11);
    bus.req_valid = 2'b11;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (gq.size() >= 4) break;
    end
    bus.req_valid = 2'b00;
    chk("cont_grants", {31'b0, gq.size() >= 4}, 32'd1);
    for (int k = 0; k < 4; k++) g[k] = (gq.size() > k) ? gq[k] : 99;
`ifdef MUL_ARB_RR_EN
    chk("cont_g0", g[0], 32'd1);
    chk("cont_g1", g[1], 32'd0);
    chk("cont_g2", g[2], 32'd1);
    chk("cont_g3", g[3], 32'd0);
`else
    chk("cont_g0", g[0], 32'd0);
    chk("cont_g1", g[1], 32'd1);
    chk("cont_g2", g[2], 32'd0);
    chk("cont_g3", g[3], 32'd1);
`endif
    repeat (25) @(negedge clk);

    // backpressure on port 0
    bus.rsp_ready[0] = 1'b0;
    issue(0, 2'b00, 32'd3, 32'd5, 5'd1, t0);
    expect_rsp(0, t0, 2'b00, 32'd15, 5'd1);
    setreq(0, 2'b00, 32'd4, 32'd4, 5'd2);
    bus.req_valid[0] = 1'b1;
    #1;
    chk("bp_ready0", {31'b0, bus.req_ready[0]}, 32'd0);
    issue(1, 2'b00, 32'd2, 32'd9, 5'd4, t1);
    expect_rsp(1, t1, 2'b00, 32'd18, 5'd4);
    chk("bp_hold", {31'b0, bus.rsp_valid[0]}, 32'd1);
    chk("bp_ready0b", {31'b0, bus.req_ready[0]}, 32'd0);
    bus.rsp_ready[0] = 1'b1;
    @(negedge clk);
    #1;
    chk("bp_drain", {31'b0, bus.rsp_valid[0]}, 32'd0);
    chk("bp_ready0c", {31'b0, bus.req_ready[0]}, 32'd1);
    t2 = cyc;
    @(negedge clk);
    bus.req_valid[0] = 1'b0;
    expect_rsp(0, t2, 2'b00, 32'd16, 5'd2);
    repeat (2) @(negedge clk);

    // flush in flight with port 1 waiting
    issue(0, 2'b00, 32'd100, 32'd3, 5'd6, t0);
    setreq(1, 2'b00, 32'd8, 32'd8, 5'd9);
    bus.req_valid[1] = 1'b1;
    while (cyc < t0 + 10) @(negedge clk);
    bus.flush[0] = 1'b1;
    @(negedge clk);
    bus.flush[0] = 1'b0;
    while (cyc < t0 + 20) @(negedge clk);
    chk("fl_done", {31'b0, bus.mul_out_valid}, 32'd1);
    @(negedge clk);
    #1;
    chk("fl_no_rsp", {31'b0, bus.rsp_valid[0]}, 32'd0);
    chk("fl_next_grant", {31'b0, bus.req_ready[1]}, 32'd1);
    t1 = cyc;
    @(negedge clk);
    bus.req_valid[1] = 1'b0;
    chk("fl_no_rsp2", {31'b0, bus.rsp_valid[0]}, 32'd0);
    expect_rsp(1, t1, 2'b00, 32'd64, 5'd9);
    repeat (2) @(negedge clk);

    // flush with request on the same port blocks accept; flush empties a full slot
    setreq(0, 2'b00, 32'd5, 32'd5, 5'd8);
    bus.req_valid[0] = 1'b1;
    bus.flush[0] = 1'b1;
    #1;
    chk("fl_req_block", {31'b0, bus.req_ready[0]}, 32'd0);
    @(negedge clk);
    bus.flush[0] = 1'b0;
    bus.rsp_ready[0] = 1'b0;
    issue(0, 2'b00, 32'd5, 32'd5, 5'd8, t0);
    expect_rsp(0, t0, 2'b00, 32'd25, 5'd8);
    bus.flush[0] = 1'b1;
    @(negedge clk);
    bus.flush[0] = 1'b0;
    chk("fl_slot", {31'b0, bus.rsp_valid[0]}, 32'd0);
    bus.rsp_ready[0] = 1'b1;
    @(negedge clk);

    // reset mid-operation
    issue(0, 2'b11, 32'hFFFF_FFFF, 32'd9, 5'd12, t0);
    while (cyc < t0 + 5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    chk("mr_req_ready", {30'b0, bus.req_ready}, 32'd0);
    chk("mr_rsp_valid", {30'b0, bus.rsp_valid}, 32'd0);
    chk("mr_rsp_data0", bus.rsp_data[0], 32'd0);
    chk("mr_in_valid", {31'b0, bus.mul_in_valid}, 32'd0);
    chk("mr_type", {30'b0, bus.mul_type}, 32'd0);
    chk("mr_opa", bus.mul_multiplicand, 32'd0);
    chk("mr_busy", {31'b0, bus.mul_busy}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    issue(0, 2'b00, 32'd11, 32'd12, 5'd7, t0);
    expect_rsp(0, t0, 2'b00, 32'd132, 5'd7);
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
